// File: rtl/data_memory_wrapper.sv
// Word-organised data memory for the load/store path.
// Byte/halfword/word writes touch only the low lanes of the addressed word;
// reads are registered and sign- or zero-extended to 32 bits. One address
// port serves both directions, and a same-edge read returns the old contents.
module data_memory_wrapper #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wrt_en,
  input  logic        mem_unsigned,
  input  logic [1:0]  width,
  input  logic [31:0] wrt_data,
  input  logic [31:0] wrt_addr,
  output logic [31:0] rd_data
);

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;

  // Storage array; deliberately not reset so it maps onto plain RAM.
  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [31:0]       rd_word;
  logic [31:0]       wr_word_d;
  logic [31:0]       rd_data_d;
  logic [31:0]       rd_data_q;

  // Upper address bits are intentionally ignored so accesses wrap modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^wrt_addr[31:ADDR_W];

  // Extend the low lanes of a stored word to 32 bits for the load result.
  function automatic logic [31:0] extend_word(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        is_unsigned
  );
    logic fill;
    case (size)
      WIDTH_BYTE: begin
        fill = ~is_unsigned & word[7];
        extend_word = {{24{fill}}, word[7:0]};
      end
      WIDTH_HALF: begin
        fill = ~is_unsigned & word[15];
        extend_word = {{16{fill}}, word[15:0]};
      end
      default: begin
        fill = 1'b0;
        extend_word = word;
      end
    endcase
  endfunction

  // Merge store data into the existing word, replacing only the written lanes.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] data,
    input logic [1:0]  size
  );
    case (size)
      WIDTH_BYTE: merge_lanes = {old_word[31:8], data[7:0]};
      WIDTH_HALF: merge_lanes = {old_word[31:16], data[15:0]};
      default:    merge_lanes = data;
    endcase
  endfunction

  // Address decode, lane merge for stores and next read result (holds when idle).
  always_comb begin
    addr      = wrt_addr[ADDR_W-1:0];
    rd_word   = mem_q[addr];
    wr_word_d = merge_lanes(rd_word, wrt_data, width);
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = extend_word(rd_word, width, mem_unsigned);
    end
  end

  // Array write; the read above sees the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (wrt_en) begin
      mem_q[addr] <= wr_word_d;
    end
  end

  // Registered read result, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_data_memory_wrapper.sv
// Bench for data_memory_wrapper: a reference model predicts rd_data for every
// cycle, the prediction is queued when the cycle is driven and compared after
// the edge. Directed cases also compare against literal values.
module tb_data_memory_wrapper;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic        wrt_en;
  logic        mem_unsigned;
  logic [1:0]  width;
  logic [31:0] wrt_data;
  logic [31:0] wrt_addr;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  data_memory_wrapper #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wrt_en       (wrt_en),
    .mem_unsigned (mem_unsigned),
    .width        (width),
    .wrt_data     (wrt_data),
    .wrt_addr     (wrt_addr),
    .rd_data      (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: rd_data=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] t;
    b = w[7:0];
    h = w[15:0];
    if (sz == 2'd0) begin
      t = b;
      return uns ? (w & 32'h0000_00FF) : t;
    end else if (sz == 2'd1) begin
      t = h;
      return uns ? (w & 32'h0000_FFFF) : t;
    end
    return w;
  endfunction

  // One bus cycle: predict, drive, step the edge, compare with the queued prediction.
  task automatic op(input string tag, input logic rd, input logic wr, input logic uns,
                    input logic [1:0] sz, input logic [31:0] data, input logic [31:0] addr);
    int a;
    logic [31:0] old;
    a = int'(addr % DEPTH);
    old = model_mem[a];
    if (rd) model_rd = model_load(old, sz, uns);
    exp_q.push_back(model_rd);
    if (wr) begin
      if (sz == 2'd0)      model_mem[a] = (old & 32'hFFFF_FF00) | (data & 32'h0000_00FF);
      else if (sz == 2'd1) model_mem[a] = (old & 32'hFFFF_0000) | (data & 32'h0000_FFFF);
      else                 model_mem[a] = data;
    end
    rd_en = rd; wrt_en = wr; mem_unsigned = uns; width = sz;
    wrt_data = data; wrt_addr = addr;
    @(posedge clk);
    #1;
    check(tag, rd_data, exp_q.pop_front());
    rd_en = 1'b0; wrt_en = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; rd_en = 1'b0; wrt_en = 1'b0; mem_unsigned = 1'b0;
    width = 2'd2; wrt_data = '0; wrt_addr = '0;
    model_rd = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1;
    check("reset_async", rd_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", rd_data, 32'h0);
    rst_n = 1'b1;

    // Byte sign/zero extension
    op("w0",        0, 1, 0, 2'd2, 32'hFFFF_FF8F, 0);
    op("rb_s",      1, 0, 0, 2'd0, 0, 0);  check("rb_s_lit", rd_data, 32'hFFFF_FF8F);
    op("rb_u",      1, 0, 1, 2'd0, 0, 0);  check("rb_u_lit", rd_data, 32'h0000_008F);
    // Halfword sign/zero extension
    op("w1",        0, 1, 0, 2'd1, 32'hFFFF_ABCD, 1);
    op("rh_s",      1, 0, 0, 2'd1, 0, 1);  check("rh_s_lit", rd_data, 32'hFFFF_ABCD);
    op("rh_u",      1, 0, 1, 2'd1, 0, 1);  check("rh_u_lit", rd_data, 32'h0000_ABCD);
    // Word reads ignore mem_unsigned
    op("w2",        0, 1, 0, 2'd2, 32'hDEAD_BEEF, 2);
    op("rw_s",      1, 0, 0, 2'd2, 0, 2);  check("rw_s_lit", rd_data, 32'hDEAD_BEEF);
    op("rw_u",      1, 0, 1, 2'd3, 0, 2);  check("rw_u_lit", rd_data, 32'hDEAD_BEEF);
    // Lane masking, half last then byte last
    op("w3",        0, 1, 0, 2'd2, 32'h1122_3344, 3);
    op("w3b",       0, 1, 0, 2'd0, 32'hFFFF_FFAA, 3);
    op("w3h",       0, 1, 0, 2'd1, 32'hFFFF_5566, 3);
    op("r3a",       1, 0, 0, 2'd2, 0, 3);  check("mask_half_last", rd_data, 32'h1122_5566);
    op("w3'",       0, 1, 0, 2'd2, 32'h1122_3344, 3);
    op("w3h'",      0, 1, 0, 2'd1, 32'hFFFF_5566, 3);
    op("w3b'",      0, 1, 0, 2'd0, 32'hFFFF_FFAA, 3);
    op("r3b",       1, 0, 0, 2'd2, 0, 3);  check("mask_byte_last", rd_data, 32'h1122_55AA);
    // Read-before-write on the same address
    op("w4",        0, 1, 0, 2'd2, 32'h0123_4567, 4);
    op("rbw",       1, 1, 0, 2'd2, 32'hCAFE_F00D, 4);  check("rbw_old", rd_data, 32'h0123_4567);
    op("rbw_next",  1, 0, 0, 2'd2, 0, 4);  check("rbw_new", rd_data, 32'hCAFE_F00D);
    // Hold when rd_en is low, then asynchronous reset between edges
    op("r2",        1, 0, 0, 2'd2, 0, 2);
    held = rd_data;
    op("hold1",     0, 0, 0, 2'd0, 0, 2);  check("hold_lit", rd_data, 32'hDEAD_BEEF);
    op("hold2",     0, 1, 1, 2'd0, 32'h0000_0077, 9);  check("hold_vs_prev", rd_data, held);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", rd_data, 32'h0);
    #1;
    rst_n = 1'b1;
    model_rd = '0;
    // Address wrap modulo DEPTH
    op("wwrap",     0, 1, 0, 2'd2, 32'h5A5A_0FF0, DEPTH + 5);
    op("rwrap",     1, 0, 0, 2'd2, 0, 5);  check("wrap_lit", rd_data, 32'h5A5A_0FF0);

    // Random traffic over a small initialised window with random upper address bits
    for (int i = 0; i < 16; i++) op("init", 0, 1, 0, 2'd2, $urandom, i);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
      op("rand", 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
